// File: rtl/gpio_bank_if.sv
// Native valid/ready peripheral bus carrying one word transfer at a time.
// The master drives the request fields; the slave answers with ready and rdata.
interface gpio_bank_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/gpio_bank.sv
// Bidirectional GPIO bank: output/direction registers, synchronised input readback,
// and per-pin rise/fall edge capture into a write-1-to-clear STATUS driving irq.
module gpio_bank #(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] DEFAULT_OUT = 32'h0,
  parameter logic [31:0] DEFAULT_DIR = 32'h0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  gpio_bank_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic                              ack;
  logic [WIDTH-1:0]                  out_q, dir_q, rise_en_q, fall_en_q, status_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [WIDTH-1:0]                  sync, rise, fall, set_bits, clr_bits;
  logic [WIDTH-1:0]                  mask, wbits;
  logic [31:0]                       byte_mask, rd_word;
  logic [2:0]                        sel;
  logic                              do_write;
  logic                              unused;

  assign sel       = bus.addr[4:2];
  assign bus.ready = bus.valid & ack;
  assign do_write  = bus.ready & (|bus.wstrb);

  // Unstrobed lanes contribute zeros, which also makes TOGGLE and STATUS ignore them.
  assign byte_mask = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}},
                      {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
  assign mask      = byte_mask[WIDTH-1:0];
  assign wbits     = bus.wdata[WIDTH-1:0] & mask;

  assign unused = ^{bus.addr[31:5], bus.addr[1:0], bus.wdata, byte_mask};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ack <= 1'b0;
    else          ack <= bus.valid & ~ack;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
      prev_q <= sync;
    end
  end

  assign sync     = sync_q[SYNC_STAGES-1];
  assign rise     = sync & ~prev_q;
  assign fall     = ~sync & prev_q;
  assign set_bits = (rise & rise_en_q) | (fall & fall_en_q);
  assign clr_bits = (do_write && sel == 3'd5) ? wbits : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= DEFAULT_OUT[WIDTH-1:0];
      dir_q     <= DEFAULT_DIR[WIDTH-1:0];
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      if (do_write && sel == 3'd0)      out_q <= (out_q & ~mask) | wbits;
      else if (do_write && sel == 3'd6) out_q <= out_q ^ wbits;
      if (do_write && sel == 3'd1) dir_q     <= (dir_q & ~mask) | wbits;
      if (do_write && sel == 3'd3) rise_en_q <= (rise_en_q & ~mask) | wbits;
      if (do_write && sel == 3'd4) fall_en_q <= (fall_en_q & ~mask) | wbits;
      // A fresh edge beats a simultaneous clear so no event is lost.
      status_q <= (status_q & ~clr_bits) | set_bits;
    end
  end

  always_comb begin
    rd_word = '0;
    if (bus.ready) begin
      case (sel)
        3'd0:    rd_word[WIDTH-1:0] = out_q;
        3'd1:    rd_word[WIDTH-1:0] = dir_q;
        3'd2:    rd_word[WIDTH-1:0] = sync;
        3'd3:    rd_word[WIDTH-1:0] = rise_en_q;
        3'd4:    rd_word[WIDTH-1:0] = fall_en_q;
        3'd5:    rd_word[WIDTH-1:0] = status_q;
        default: rd_word = '0;
      endcase
    end
  end

  assign bus.rdata = rd_word;
  assign gpio_o    = out_q;
  assign gpio_oe   = dir_q;
  assign irq       = |status_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: reset values, strobes, toggle, edge timing,
// W1C collision, back-to-back transfers and reset during a transfer.
module tb_gpio_bank;

  localparam logic [31:0] A_OUT    = 32'h00;
  localparam logic [31:0] A_DIR    = 32'h04;
  localparam logic [31:0] A_IN     = 32'h08;
  localparam logic [31:0] A_RISE   = 32'h0C;
  localparam logic [31:0] A_FALL   = 32'h10;
  localparam logic [31:0] A_STATUS = 32'h14;
  localparam logic [31:0] A_TOGGLE = 32'h18;
  localparam logic [31:0] A_RSVD   = 32'h1C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] gpio_i;
  logic [31:0] gpio_o, gpio_oe;
  logic        irq;
  int          checks = 0;
  int          failures = 0;

  gpio_bank_if bus ();

  gpio_bank #(
    .WIDTH(32), .DEFAULT_OUT(32'hA5), .DEFAULT_DIR(32'h0F), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output int lat);
    @(negedge clk);
    bus.valid = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = s;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.ready && lat < 8);
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bus_timeout addr=%h got ready=%b want 1", a, bus.ready);
    end
    rd = bus.rdata;
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.wstrb = 4'h0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int lat;
    bus_xfer(a, d, s, rd, lat);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] rd);
    int lat;
    bus_xfer(a, 32'h0, 4'h0, rd, lat);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    int lat;
    wait_cycles(3);
    checks++;
    if (gpio_o !== 32'hA5 || gpio_oe !== 32'h0F || irq !== 1'b0 || bus.ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got o=%h oe=%h irq=%b ready=%b want o=a5 oe=0f irq=0 ready=0",
               gpio_o, gpio_oe, irq, bus.ready);
    end
    @(negedge clk); reset_n = 1'b1;
    wait_cycles(1);
    bus_xfer(A_OUT, 32'h0, 4'h0, rd, lat);
    checks++;
    if (rd !== 32'hA5) begin
      failures++; $display("[TB] FAIL reset_read_out got %h want 000000a5", rd);
    end
    checks++;
    if (lat !== 1) begin
      failures++; $display("[TB] FAIL ready_latency got %0d want 1", lat);
    end
    bus_read(A_DIR, rd);
    checks++;
    if (rd !== 32'h0F) begin
      failures++; $display("[TB] FAIL reset_read_dir got %h want 0000000f", rd);
    end
    bus_read(A_RSVD, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++; $display("[TB] FAIL reserved_read got %h want 0", rd);
    end
  endtask

  task automatic test_strobes;
    logic [31:0] rd;
    bus_write(A_OUT, 32'hFFFF_FFFF, 4'hF);
    bus_write(A_OUT, 32'h1234_5678, 4'b0101);
    checks++;
    if (gpio_o !== 32'hFF34_FF78) begin
      failures++; $display("[TB] FAIL strobe_gpio_o got %h want ff34ff78", gpio_o);
    end
    bus_read(A_OUT, rd);
    checks++;
    if (rd !== 32'hFF34_FF78) begin
      failures++; $display("[TB] FAIL strobe_read got %h want ff34ff78", rd);
    end
  endtask

  task automatic test_toggle;
    logic [31:0] rd;
    bus_write(A_OUT, 32'h0000_000F, 4'hF);
    bus_write(A_TOGGLE, 32'h0000_00F0, 4'hF);
    checks++;
    if (gpio_o !== 32'hFF) begin
      failures++; $display("[TB] FAIL toggle_gpio_o got %h want 000000ff", gpio_o);
    end
    bus_read(A_TOGGLE, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++; $display("[TB] FAIL toggle_read got %h want 0", rd);
    end
    bus_write(A_TOGGLE, 32'h0000_0101, 4'b0001);
    checks++;
    if (gpio_o !== 32'hFE) begin
      failures++; $display("[TB] FAIL toggle_strobe got %h want 000000fe", gpio_o);
    end
  endtask

  task automatic test_rise_edge;
    logic [31:0] rd;
    bus_write(A_RISE, 32'h1, 4'hF);
    bus_write(A_STATUS, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++; $display("[TB] FAIL status_idle got %h want 0", rd);
    end
    @(negedge clk); gpio_i[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("[TB] FAIL irq_early_n got %b want 0", irq);
    end
    bus.valid = 1'b1; bus.addr = A_IN; bus.wstrb = 4'h0;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.rdata !== 32'h1) begin
      failures++;
      $display("[TB] FAIL in_sync_latency got ready=%b rdata=%h want ready=1 rdata=1",
               bus.ready, bus.rdata);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("[TB] FAIL irq_early_n1 got %b want 0", irq);
    end
    @(posedge clk); #1;
    bus.valid = 1'b0;
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("[TB] FAIL irq_rise_latency got %b want 1", irq);
    end
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h1) begin
      failures++; $display("[TB] FAIL status_rise got %h want 1", rd);
    end
    bus_write(A_STATUS, 32'h1, 4'hF);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("[TB] FAIL w1c_clear got irq=%b want 0", irq);
    end
    @(negedge clk); gpio_i[0] = 1'b0;
    wait_cycles(4);
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0 || irq !== 1'b0) begin
      failures++; $display("[TB] FAIL fall_ignored got status=%h irq=%b want 0 0", rd, irq);
    end
  endtask

  task automatic test_w1c_collision;
    logic [31:0] rd;
    @(negedge clk); gpio_i[0] = 1'b1;
    wait_cycles(4);
    @(negedge clk); gpio_i[0] = 1'b0;
    wait_cycles(4);
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("[TB] FAIL pending_status got irq=%b want 1", irq);
    end
    @(negedge clk); gpio_i[0] = 1'b1;
    @(negedge clk);
    bus.valid = 1'b1; bus.addr = A_STATUS; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++; $display("[TB] FAIL collision_ready got %b want 1", bus.ready);
    end
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.wstrb = 4'h0;
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("[TB] FAIL collision_set_wins got irq=%b want 1", irq);
    end
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h1) begin
      failures++; $display("[TB] FAIL collision_status got %h want 1", rd);
    end
    bus_write(A_STATUS, 32'h1, 4'hF);
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0 || irq !== 1'b0) begin
      failures++; $display("[TB] FAIL second_w1c got status=%h irq=%b want 0 0", rd, irq);
    end
  endtask

  task automatic test_back_to_back;
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.valid = 1'b1; bus.addr = A_TOGGLE; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (bus.ready !== ((k % 2) == 1)) begin
        failures++; $display("[TB] FAIL b2b_ready_c%0d got %b want %0d", k, bus.ready, k % 2);
      end
      if (bus.ready === 1'b1) pulses++;
    end
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.wstrb = 4'h0;
    checks++;
    if (pulses !== 3) begin
      failures++; $display("[TB] FAIL b2b_pulses got %0d want 3", pulses);
    end
    checks++;
    if (gpio_o !== 32'hFF) begin
      failures++; $display("[TB] FAIL b2b_toggles got %h want 000000ff", gpio_o);
    end
  endtask

  task automatic test_reset_mid_transfer;
    @(negedge clk);
    bus.valid = 1'b1; bus.addr = A_OUT; bus.wdata = 32'h0; bus.wstrb = 4'hF;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++; $display("[TB] FAIL midreset_pending got ready=%b want 1", bus.ready);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_ready got %b want 0", bus.ready);
    end
    bus.valid = 1'b0; bus.wstrb = 4'h0;
    wait_cycles(1);
    @(negedge clk); reset_n = 1'b1;
    wait_cycles(2);
    checks++;
    if (gpio_o !== 32'hA5 || gpio_oe !== 32'h0F || irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_regs got o=%h oe=%h irq=%b want a5 0f 0", gpio_o, gpio_oe, irq);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    gpio_i    = 32'h0;
    bus.valid = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    bus.wstrb = 4'h0;
    test_reset();
    test_strobes();
    test_toggle();
    test_rise_edge();
    test_w1c_collision();
    test_back_to_back();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised bidirectional GPIO bank on the native valid/ready memory bus. It provides per-pin output data, a per-pin direction (output-enable) register, synchronised input readback, and per-pin rising/falling edge interrupts with write-1-to-clear status. It sits on the peripheral bus beside the UART and timer blocks and drives one level-sensitive `irq` line to the core. It is the successor to the write-only output port: output reset value stays configurable, and register readback is now supported.

## Interface
- `WIDTH`, 32 — number of pins, 1..32; register bits at and above `WIDTH` read 0 and ignore writes.
- `DEFAULT_OUT`, 32'h0 — reset value of OUT.
- `DEFAULT_DIR`, 32'h0 — reset value of DIR (1 = output).
- `SYNC_STAGES`, 2 — input synchroniser depth, 2..4.

Ports:
- `clk` in 1 — clock clk.
- `reset_n` in 1 — reset reset_n, asynchronous, active-low.
- `valid` in 1 — bus request.
- `ready` out 1 — transfer complete.
- `addr` in 32 — byte address; only `addr[4:2]` is decoded.
- `rdata` out 32 — read data, valid while `ready`=1.
- `wdata` in 32 — write data.
- `wstrb` in 4 — byte-lane write strobes; 0 = read.
- `gpio_i` in WIDTH — pad inputs, asynchronous.
- `gpio_o` out WIDTH — pad output data (= OUT).
- `gpio_oe` out WIDTH — pad output enables (= DIR).
- `irq` out 1 — interrupt request.

## Operation
Register map (`addr[4:2]`):
- 0 OUT (rw).
- 1 DIR (rw).
- 2 IN (ro): synchroniser output.
- 3 RISE_EN (rw).
- 4 FALL_EN (rw).
- 5 STATUS (rw1c).
- 6 TOGGLE (wo): OUT ^= written bits; reads 0.
- 7 reserved: reads 0, writes ignored.

Bus and register rules:
- Writes honour `wstrb` per byte lane. For TOGGLE and STATUS, unstrobed lanes act as 0.
- A write is applied at the clock edge that ends the `ready` cycle. It takes effect exactly once per transfer.
- Input path: each `gpio_i` bit passes through a `SYNC_STAGES` flop chain, then a one-flop delay `prev`.
  - rise = sync & ~prev; fall = ~sync & prev.
- Edge detection runs on every pin regardless of DIR.
- STATUS[i] is set when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- STATUS[i] is cleared by writing 1 to it. If set and clear occur in the same cycle, set wins.
- Clearing RISE_EN/FALL_EN does not clear STATUS.
- `irq` = |STATUS, driven combinationally from the STATUS flops.

Reset values (all asynchronous):
- OUT=DEFAULT_OUT, DIR=DEFAULT_DIR, RISE_EN=FALL_EN=STATUS=0.
- Synchroniser and `prev` flops = 0.
- Ack flop = 0, so `ready`=0, `rdata`=0, `irq`=0.
- A rising input present at reset release may therefore report a rise edge once the enables are set. Software clears STATUS after enabling.

## Timing
Handshake:
- Internal flop `ack`: next = `valid & ~ack`. `ready` = `valid & ack`.
- Request in cycle 0 gives `ready`=1 in cycle 1, then `ack` drops.
- A master holding `valid` gets one transfer every 2 cycles.
- `valid` dropped while `ack`=1 aborts without side effect; `ack` clears next edge.
- `addr`, `wdata` and `wstrb` must be stable from `valid` rise until `ready`.
- `rdata` is combinational from `addr` and the registers during `ready`; it is 0 otherwise.

Latencies:
- A write to OUT/DIR/TOGGLE is visible on `gpio_o`/`gpio_oe` immediately after the completing edge.
- Input change before edge 1 reaches IN after edge `SYNC_STAGES`.
- STATUS and `irq` rise after edge `SYNC_STAGES`+1.
- Pulses shorter than one clk period may be missed (no latching on raw pins).
- Reset mid-transfer: `ready` drops immediately and no write is applied. The master must reissue.

## Test plan
- Reset values: with `DEFAULT_OUT`=32'hA5, `DEFAULT_DIR`=32'h0F, release reset.
  - Expect `gpio_o`=0xA5, `gpio_oe`=0x0F, `irq`=0.
  - Read addr 0x0 gives 0xA5; `ready` appears exactly 1 cycle after `valid`.
- Byte strobes: write OUT=0x1234_5678 with `wstrb`=4'b0101 over 0xFFFF_FFFF. Expect OUT=0xFF34_FF78.
- TOGGLE: write TOGGLE=0x0000_00F0 with OUT=0x0F. Expect `gpio_o`=0xFF; a TOGGLE read returns 0.
- Rising edge with `SYNC_STAGES`=2: RISE_EN=0x1, drive `gpio_i[0]` 0→1 before edge N.
  - Expect IN[0]=1 after edge N+1, STATUS=0x1 and `irq`=1 after edge N+2.
  - A falling edge on the same pin does not set STATUS (FALL_EN=0).
- W1C collision: hold a pending STATUS[0] and complete a write STATUS=0x1 in the same cycle a new rise on pin 0 is detected.
  - Expect STATUS[0]=1 and `irq` still 1. A second W1C clears it and `irq`=0.
- Back-to-back with `valid` held for 6 cycles: expect 3 `ready` pulses at cycles 1, 3, 5. Assert `reset_n` low during a pending write: no register change.
